// File: rtl/snn_pkg.sv
// ---------------------------------------------------------------------------
// snn_pkg
//   Shared types and widths for the SNN layer datapath.
//   - sched_state_t : layer scheduler FSM states
//   - SPIKE_W       : spikes per input vector
//   - WEIGHT_W      : bits per signed synaptic weight
//   - CURRENT_W     : bits of the signed input current
//   - WORD_W        : one neuron's packed weight word (SPIKE_W * WEIGHT_W)
// ---------------------------------------------------------------------------
package snn_pkg;

   localparam int SPIKE_W   = 8;
   localparam int WEIGHT_W  = 2;
   localparam int CURRENT_W = 5;
   localparam int WORD_W    = SPIKE_W * WEIGHT_W;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      LOAD  = 3'd2,
      CALC  = 3'd3,
      EMIT  = 3'd4
   } sched_state_t;

endpackage

// File: rtl/snn_layer_scheduler.sv
// ---------------------------------------------------------------------------
// snn_layer_scheduler
//   Time-shares one external input-current calculator across the neurons of
//   a layer. On start it latches the spike vector, then per neuron: reads the
//   weight word, registers it for the calculator, captures the calculator's
//   current, and hands it downstream over valid/ready. An all-zero spike
//   vector skips the memory and calculator and emits zero currents back to
//   back.
//
// Ports
//   clk, reset            : clock, asynchronous active-high reset
//   start, input_spikes   : pass request and spike vector (latched on start)
//   weight_rd_en/addr     : weight memory read strobe and neuron address
//   weight_data           : weight word, one cycle after the read strobe
//   calc_spikes/weights   : operands to the shared calculator
//   calc_current          : combinational calculator result
//   current_valid/ready   : downstream handshake
//   current_out/neuron_idx: presented current and its neuron
//   busy, done            : pass in progress / end-of-pass pulse
// ---------------------------------------------------------------------------
module snn_layer_scheduler
   import snn_pkg::*;
#(
   parameter int N_NEURONS = 8,
   parameter int IDX_W     = $clog2(N_NEURONS)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [SPIKE_W-1:0]   input_spikes,
   output logic                 weight_rd_en,
   output logic [IDX_W-1:0]     weight_addr,
   input  logic [WORD_W-1:0]    weight_data,
   output logic [SPIKE_W-1:0]   calc_spikes,
   output logic [WORD_W-1:0]    calc_weights,
   input  logic [CURRENT_W-1:0] calc_current,
   output logic                 current_valid,
   input  logic                 current_ready,
   output logic [CURRENT_W-1:0] current_out,
   output logic [IDX_W-1:0]     neuron_idx,
   output logic                 busy,
   output logic                 done
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);

   sched_state_t           state_q, state_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [SPIKE_W-1:0]     spk_q, spk_d;
   logic [WORD_W-1:0]      w_q, w_d;
   logic [CURRENT_W-1:0]   cur_q, cur_d;
   logic                   done_q, done_d;

   logic last_nrn;
   logic fast;
   logic hs;

   assign last_nrn = (idx_q == LAST_IDX);
   // The latch is only ever zero during a pass when the pass took the fast path.
   assign fast     = (spk_q == '0);
   assign hs       = (state_q == EMIT) && current_ready;

   // ---- FSM: state register ----
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // ---- FSM: next state ----
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:  if (start) state_d = (input_spikes == '0) ? EMIT : FETCH;
         FETCH: state_d = LOAD;
         LOAD:  state_d = CALC;
         CALC:  state_d = EMIT;
         EMIT: begin
            if (current_ready) begin
               if (last_nrn)  state_d = IDLE;
               else if (fast) state_d = EMIT;
               else           state_d = FETCH;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // ---- FSM: outputs ----
   always_comb begin
      weight_rd_en  = (state_q == FETCH);
      current_valid = (state_q == EMIT);
      busy          = (state_q != IDLE);
   end

   // ---- datapath next state ----
   always_comb begin
      idx_d  = idx_q;
      spk_d  = spk_q;
      w_d    = w_q;
      cur_d  = cur_q;
      done_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               spk_d = input_spikes;
               idx_d = '0;
               // Zero here doubles as the fast-path current for every neuron.
               cur_d = '0;
            end
         end
         LOAD: w_d   = weight_data;
         CALC: cur_d = calc_current;
         EMIT: begin
            if (hs) begin
               if (last_nrn) done_d = 1'b1;
               else          idx_d  = idx_q + IDX_W'(1);
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         idx_q  <= '0;
         spk_q  <= '0;
         w_q    <= '0;
         cur_q  <= '0;
         done_q <= 1'b0;
      end else begin
         idx_q  <= idx_d;
         spk_q  <= spk_d;
         w_q    <= w_d;
         cur_q  <= cur_d;
         done_q <= done_d;
      end
   end

   assign weight_addr  = idx_q;
   assign calc_spikes  = spk_q;
   assign calc_weights = w_q;
   assign current_out  = cur_q;
   assign neuron_idx   = idx_q;
   assign done         = done_q;

endmodule

// File: doc/snn_layer_scheduler.md
# snn_layer_scheduler

Sequencer that time-shares one input current calculator (8 spikes × 2-bit signed weights → 5-bit signed current) across all neurons of a layer. On `start` it latches the 8-bit input spike vector, then for each neuron in turn fetches that neuron's 16-bit weight word from the weight memory, presents spikes and weights to the calculator, and captures the resulting current. It delivers each current downstream through a valid/ready handshake. It sits between the input spike register, the weight memory, and the neuron update stage.

## Interface
- `N_NEURONS`, default 8: neurons per layer; legal range 2..256.
- `IDX_W`, default `$clog2(N_NEURONS)`: width of the neuron index and the weight address.
- `clk` input 1: the block's single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high; clears all state.
- `start` input 1: begin a layer pass; sampled only in IDLE.
- `input_spikes` input 8: spike vector, latched on the accepted `start`.
- `weight_rd_en` output 1: weight memory read strobe.
- `weight_addr` output IDX_W: neuron index to read.
- `weight_data` input 16: weight word; valid exactly 1 cycle after `weight_rd_en`.
- `calc_spikes` output 8: to calculator; always equals the latched spikes.
- `calc_weights` output 16: to calculator; always equals the registered weight word.
- `calc_current` input 5: combinational calculator result, two's complement.
- `current_valid` output 1: a current is presented downstream.
- `current_ready` input 1: downstream accepts the presented current.
- `current_out` output 5: signed current for `neuron_idx`.
- `neuron_idx` output IDX_W: index of the neuron whose current is presented.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle pulse after the last neuron's handshake.

## Operation
- FSM states and transitions:
  - IDLE → FETCH on `start`, or → EMIT on `start` when `input_spikes == 0` (zero-spike fast path).
  - FETCH: drive `weight_rd_en = 1` with `weight_addr = idx`; → LOAD.
  - LOAD: register `weight_data` into `w_reg`; → CALC.
  - CALC: register `calc_current` into `cur_reg`; → EMIT.
  - EMIT: drive `current_valid = 1`. On `current_ready`:
    - if `idx == N_NEURONS-1`, → IDLE and pulse `done`;
    - otherwise increment `idx` and → FETCH, or → EMIT again on the fast path.
- Zero-spike fast path:
  - No weight reads are issued.
  - `cur_reg` is forced to 0 for every neuron.
  - Indices still step 0..N-1, one neuron per accepted handshake.
- `start` while busy is ignored. `input_spikes` changes after the latch have no effect.
- Current range for 8 inputs with weights in −2..+1 is −16..+8. The block passes `calc_current` through unchanged, with no extension or saturation.
- `current_out` and `neuron_idx` are stable while `current_valid` is high and `current_ready` is low.
- `weight_rd_en` is high only in FETCH, exactly once per neuron on the normal path.
- Reset values: every output is 0; internal `idx`, the spike latch, `w_reg`, `cur_reg` and the state (IDLE) are also 0.
- Reset mid-pass aborts immediately: no `done` pulse, and any pending current is discarded.

## Timing
- `start` sampled high at edge 0: `busy` and `weight_rd_en` are high from edge 0 on (FETCH, neuron 0).
- With `current_ready` held high:
  - `current_valid` for neuron 0 first rises after edge 3;
  - each neuron takes 4 cycles;
  - `done` is high in the cycle after the final handshake edge (4·N_NEURONS), and `busy` is low in that same cycle.
- Fast path with `current_ready` held high: one current per cycle; `done` is high in the cycle after edge N_NEURONS.
- A new `start` may be accepted in the cycle in which `done` is high.
- Each cycle `current_ready` is low in EMIT adds one cycle to the pass. There is no other source of stall.

## Structure
- Shared package `snn_pkg`:
  - state enum `sched_state_t` (IDLE, FETCH, LOAD, CALC, EMIT);
  - constants `SPIKE_W=8`, `WEIGHT_W=2`, `CURRENT_W=5`.
- The calculator is instantiated outside this block, so it can be shared or configured elsewhere.
- No sub-module is required. The FSM, index counter and capture registers stay in a single module.

## Test plan
- N=8; spikes 0xFF; every weight word 0x5555 (+1 each); ready high.
  - Currents 8 for idx 0..7.
  - `done` high in the cycle after edge 32.
  - Exactly 8 `weight_rd_en` pulses, at addresses 0..7.
- Spikes 0x0F; weights 0xAAAA (−2 each) → current 0x18 (−8) for every neuron.
- Spikes 0x00 → fast path:
  - no `weight_rd_en`;
  - 8 zero currents on consecutive cycles;
  - `done` high in the cycle after edge 8.
- Spikes 0xFF; weights 0x5555.
  - Hold `current_ready` low for 5 cycles at neuron 3 → `current_out` (8) and `neuron_idx` (3) stay stable.
  - `done` is delayed by 5 cycles.
  - A `start` pulse mid-pass is ignored.
- Assert `reset` during LOAD of neuron 2:
  - all outputs are 0 immediately;
  - no `done` pulse;
  - the next `start` restarts at idx 0 with the new spikes.
